pwm_ramp_sequencer: RTL and testbench
=====================================

Name: pwm_ramp_sequencer

Overview:
- Avalon-slave-configured controller that drives the existing PWM's Avalon slave port (div at addr 0, duty at addr 1) as a zero-wait write-only master.
- On start it writes the period divider, then ramps duty from the current value to a target in programmable steps at a programmable tick interval.
- Sits between the CPU bus and the PWM so software issues one command per fade instead of timed register writes.

Parameters:
- DW, 32, data width of all duty/div/step registers and both data buses.
- IW, 16, width of the interval counter (ticks between duty steps).

Ports:
- clk  in  1  clock.
- clr_n  in  1  reset, asynchronous, active-low.
- s_cs  in  1  slave chip select.
- s_wr_n  in  1  slave write strobe, active-low.
- s_addr  in  2  slave register select: 0 DIV, 1 TARGET, 2 STEP, 3 CTRL.
- s_wr_data  in  DW  slave write data.
- s_rd_data  out  DW  slave read data, combinational from s_addr.
- m_cs  out  1  master chip select to PWM.
- m_wr_n  out  1  master write strobe, active-low.
- m_addr  out  1  PWM register select: 0 div, 1 duty.
- m_wr_data  out  DW  data to PWM.

Behaviour:
- Slave write with s_cs=1, s_wr_n=0 at posedge: addr0 sets div, addr1 sets target, addr2 sets step.
- CTRL write fields: bit0 start, bit1 abort, bits[31:16] interval.
- Reads: addr0 div; addr1 cur (current duty), not target; addr2 step; addr3 {interval, 14'b0, done, busy}.
- Reset: div, target, step, interval, cur all 0; busy=0, done=0; state IDLE; m_cs=0, m_wr_n=1, m_addr=0, m_wr_data=0.
- Master outputs are registered. A write is exactly one cycle with m_cs=1 and m_wr_n=0; otherwise m_cs=0 and m_wr_n=1. There is no waitrequest.
- States:
  - IDLE: start moves to WR_DIV; busy=1; done cleared.
  - WR_DIV: issue write addr0=div. Next state WR_DUTY.
  - WR_DUTY: issue write addr1=cur. If cur==target, go to DONE. Else if interval==0, go to STEP. Else load tick counter with interval and go to WAIT.
  - WAIT: decrement the counter; at 1, go to STEP.
  - STEP: cur := next(cur), then go to WR_DUTY.
  - DONE: done=1, busy=0, go to IDLE.
- Latency: start written at edge N gives the div write visible in cycle N+1 and the first duty write in cycle N+2. With interval I>0, consecutive duty writes are I+2 cycles apart; with I=0, they are 2 cycles apart.
- Step arithmetic is unsigned DW-bit with no overshoot and no wrap:
  - Ramping up: cur+step if target-cur > step, else target.
  - Ramping down: cur-step if cur-target > step, else target.
  - step==0 jumps directly to target.
- Start while busy is ignored.
- Abort has priority over start in the same write. It forces IDLE on the next edge from any state, with no further master writes. busy=0; done stays 0; cur keeps its last value.
- Writes to div/target/step/interval while busy take effect at their next use; target changes redirect the ramp.
- s_cs=0 or a non-write has no effect on state.
- Reset asserted mid-ramp returns everything to reset values immediately, including deasserting m_cs.

Optional Feature:
- Macro PWM_RAMP_SEQ_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) and CTRL bit2 irq_en (readable at addr3 bit2).
  - irq = done & irq_en, registered.
  - A CTRL write with bit3=1 clears done.
- Undefined:
  - No irq port; CTRL bits 2-3 ignored and read as 0.
  - done is cleared only by the next start.

Decomposition:
- Package pwm_ramp_seq_pkg: state enum (IDLE, WR_DIV, WR_DUTY, WAIT, STEP, DONE), slave address constants (0-3), PWM address constants (0 div, 1 duty), CTRL bit indices.
- Sub-module pwm_ramp_step: combinational next-duty calculator (cur, target, step -> next). Unit-testable in isolation for the saturation rules.

Test Plan:
- Reset mid-ramp: assert clr_n=0 during WAIT -> m_cs=0 and m_wr_n=1 immediately; all reads return 0 after release.
- Ramp up: div=100, target=10, step=4, interval=0, start -> PWM writes div=100, then duty 0, 4, 8, 10; then done=1, busy=0; no overshoot.
- Ramp down with interval: cur=10, target=1, step=3, interval=5 -> duty writes 7, 4, 1 spaced 7 cycles apart; read addr1 returns 1.
- step=0: cur=0, target=50 -> exactly one duty write 0, then one duty write 50, then done.
- Abort and re-arm:
  - Abort during WAIT -> no further m_cs pulses; busy=0, done=0; cur holds its value.
  - Start during busy -> ignored; no second div write.
- IRQ (macro defined): irq_en=1, complete a ramp -> irq=1 one cycle after done; CTRL write bit3 -> irq=0 next cycle.

Source files
------------

// File: rtl/pwm_ramp_seq_pkg.sv
// Shared definitions for the PWM ramp sequencer: FSM state encoding, slave
// register map, PWM register map and CTRL field positions.
package pwm_ramp_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrDiv,
        StWrDuty,
        StWait,
        StStep,
        StDone
    } state_e;

    // Slave register map
    localparam logic [1:0] AddrDiv    = 2'd0;
    localparam logic [1:0] AddrTarget = 2'd1;
    localparam logic [1:0] AddrStep   = 2'd2;
    localparam logic [1:0] AddrCtrl   = 2'd3;

    // PWM register map
    localparam logic PwmAddrDiv  = 1'b0;
    localparam logic PwmAddrDuty = 1'b1;

    // CTRL write fields
    localparam int unsigned CtrlStart   = 0;
    localparam int unsigned CtrlAbort   = 1;
    localparam int unsigned CtrlIrqEn   = 2;
    localparam int unsigned CtrlDoneClr = 3;
    localparam int unsigned CtrlIntLsb  = 16;

    // CTRL read fields
    localparam int unsigned StatBusy = 0;
    localparam int unsigned StatDone = 1;

endpackage

// File: rtl/pwm_ramp_step.sv
// Next-duty calculator for the ramp sequencer.
// Moves cur one step toward target, saturating at target (no overshoot, no
// wrap). A zero step jumps straight to target.
// Ports:
//   cur    - current duty value
//   target - final duty value
//   step   - ramp increment magnitude
//   next   - duty value after one step
module pwm_ramp_step #(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] cur,
    input  logic [DW-1:0] target,
    input  logic [DW-1:0] step,
    output logic [DW-1:0] next
);

    always_comb begin
        next = target;
        if (step != '0) begin
            if (target > cur) begin
                if ((target - cur) > step) begin
                    next = cur + step;
                end
            end else if (cur > target) begin
                if ((cur - target) > step) begin
                    next = cur - step;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// PWM ramp sequencer: slave-configured controller that programs the PWM
// divider and then fades the PWM duty toward a target in steps, writing the
// PWM through a zero-wait, write-only master port.
// Optional feature: define PWM_RAMP_SEQ_IRQ_EN to add the irq output, the
// CTRL irq_en bit (bit2) and the CTRL done-clear bit (bit3).
// Ports:
//   clk, clr_n          - clock, asynchronous active-low reset
//   s_cs, s_wr_n        - slave chip select, active-low write strobe
//   s_addr, s_wr_data   - slave register select (DIV/TARGET/STEP/CTRL), data
//   s_rd_data           - slave read data, combinational from s_addr
//   m_cs, m_wr_n        - master chip select, active-low write strobe
//   m_addr, m_wr_data   - PWM register select (0 div, 1 duty), data
//   irq                 - done & irq_en, registered (optional)
module pwm_ramp_sequencer
    import pwm_ramp_seq_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned IW = 16
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          s_cs,
    input  logic          s_wr_n,
    input  logic [1:0]    s_addr,
    input  logic [DW-1:0] s_wr_data,
    output logic [DW-1:0] s_rd_data,
    output logic          m_cs,
    output logic          m_wr_n,
    output logic          m_addr,
    output logic [DW-1:0] m_wr_data
`ifdef PWM_RAMP_SEQ_IRQ_EN
    ,
    output logic          irq
`endif
);

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, target_q, step_q, cur_q, cur_d, next_duty;
    logic [IW-1:0] interval_q, cnt_q, cnt_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          mcs_d, maddr_d;
    logic [DW-1:0] mdata_d;
    logic          wr_en, ctrl_wr, start_req, abort_req;
    logic          unused_wr_data;

    assign wr_en     = s_cs & ~s_wr_n;
    assign ctrl_wr   = wr_en && (s_addr == AddrCtrl);
    assign start_req = ctrl_wr & s_wr_data[CtrlStart];
    assign abort_req = ctrl_wr & s_wr_data[CtrlAbort];

    assign unused_wr_data = ^s_wr_data;

`ifdef PWM_RAMP_SEQ_IRQ_EN
    logic irq_en_q;
`endif

    // Configuration registers; updates while busy are picked up at next use.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            div_q      <= '0;
            target_q   <= '0;
            step_q     <= '0;
            interval_q <= '0;
`ifdef PWM_RAMP_SEQ_IRQ_EN
            irq_en_q   <= 1'b0;
`endif
        end else if (wr_en) begin
            case (s_addr)
                AddrDiv:    div_q    <= s_wr_data;
                AddrTarget: target_q <= s_wr_data;
                AddrStep:   step_q   <= s_wr_data;
                default: begin
                    interval_q <= s_wr_data[CtrlIntLsb +: IW];
`ifdef PWM_RAMP_SEQ_IRQ_EN
                    irq_en_q   <= s_wr_data[CtrlIrqEn];
`endif
                end
            endcase
        end
    end

    pwm_ramp_step #(
        .DW (DW)
    ) u_step (
        .cur    (cur_q),
        .target (target_q),
        .step   (step_q),
        .next   (next_duty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        busy_d  = busy_q;
        done_d  = done_q;
        mcs_d   = 1'b0;
        maddr_d = m_addr;
        mdata_d = m_wr_data;
        if (abort_req) begin
            // Abort wins over start and suppresses any write due this edge.
            state_d = StIdle;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_req) begin
                        state_d = StWrDiv;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
                StWrDiv: begin
                    mcs_d   = 1'b1;
                    maddr_d = PwmAddrDiv;
                    mdata_d = div_q;
                    state_d = StWrDuty;
                end
                StWrDuty: begin
                    mcs_d   = 1'b1;
                    maddr_d = PwmAddrDuty;
                    mdata_d = cur_q;
                    if (cur_q == target_q) begin
                        state_d = StDone;
                    end else if (interval_q == '0) begin
                        state_d = StStep;
                    end else begin
                        cnt_d   = interval_q;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= 1) begin
                        state_d = StStep;
                    end
                end
                StStep: begin
                    cur_d   = next_duty;
                    state_d = StWrDuty;
                end
                StDone: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
`ifdef PWM_RAMP_SEQ_IRQ_EN
        if (ctrl_wr && s_wr_data[CtrlDoneClr]) begin
            done_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cur_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            m_cs      <= 1'b0;
            m_wr_n    <= 1'b1;
            m_addr    <= 1'b0;
            m_wr_data <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            m_cs      <= mcs_d;
            m_wr_n    <= ~mcs_d;
            m_addr    <= maddr_d;
            m_wr_data <= mdata_d;
        end
    end

`ifdef PWM_RAMP_SEQ_IRQ_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            irq <= 1'b0;
        end else begin
            irq <= done_q & irq_en_q;
        end
    end
`endif

    // Address 1 reads back the live duty, not the programmed target.
    always_comb begin
        s_rd_data = '0;
        case (s_addr)
            AddrDiv:    s_rd_data = div_q;
            AddrTarget: s_rd_data = cur_q;
            AddrStep:   s_rd_data = step_q;
            default: begin
                s_rd_data[CtrlIntLsb +: IW] = interval_q;
                s_rd_data[StatDone]         = done_q;
                s_rd_data[StatBusy]         = busy_q;
`ifdef PWM_RAMP_SEQ_IRQ_EN
                s_rd_data[CtrlIrqEn]        = irq_en_q;
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
module tb_pwm_ramp_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned IW = 16;

    logic          clk;
    logic          clr_n;
    logic          s_cs;
    logic          s_wr_n;
    logic [1:0]    s_addr;
    logic [DW-1:0] s_wr_data;
    logic [DW-1:0] s_rd_data;
    logic          m_cs;
    logic          m_wr_n;
    logic          m_addr;
    logic [DW-1:0] m_wr_data;
`ifdef PWM_RAMP_SEQ_IRQ_EN
    logic          irq;
`endif

    pwm_ramp_sequencer #(
        .DW (DW),
        .IW (IW)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .s_cs      (s_cs),
        .s_wr_n    (s_wr_n),
        .s_addr    (s_addr),
        .s_wr_data (s_wr_data),
        .s_rd_data (s_rd_data),
        .m_cs      (m_cs),
        .m_wr_n    (m_wr_n),
        .m_addr    (m_addr),
        .m_wr_data (m_wr_data)
`ifdef PWM_RAMP_SEQ_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_wr  = 0;
    int start_cyc = 0;
    logic [32:0] exp_q[$];
    int          wr_cyc[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every master write pops and checks the next expected write.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (m_cs === 1'b1) begin
                n_wr++;
                wr_cyc.push_back(cyc);
                check("m_wr_n_low", {63'd0, m_wr_n}, 64'd0);
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_wr: observed=%0h expected=none",
                           {m_addr, m_wr_data});
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("m_write", {31'd0, m_addr, m_wr_data}, {31'd0, e});
                end
            end
        end
    end

    task automatic push_wr(input logic a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic sl_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        s_cs      = 1'b1;
        s_wr_n    = 1'b0;
        s_addr    = a;
        s_wr_data = d;
        @(negedge clk);
        s_cs      = 1'b0;
        s_wr_n    = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic sl_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        s_addr = a;
        #1;
        check(tag, {32'd0, s_rd_data}, {32'd0, exp});
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            s_addr = 2'd3;
            #1;
            if (s_rd_data[1] === 1'b1) seen = 1;
        end
        check(tag, {63'd0, seen}, 64'd1);
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && n_wr < n; i++) @(negedge clk);
        check(tag, {63'd0, (n_wr >= n)}, 64'd1);
    endtask

    initial begin
        int base;
        clr_n     = 1'b0;
        s_cs      = 1'b0;
        s_wr_n    = 1'b1;
        s_addr    = 2'd0;
        s_wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_m_cs", {63'd0, m_cs}, 64'd0);
        check("rst_m_wr_n", {63'd0, m_wr_n}, 64'd1);
        check("rst_m_addr", {63'd0, m_addr}, 64'd0);
        check("rst_m_data", {32'd0, m_wr_data}, 64'd0);
        clr_n = 1'b1;
        sl_read("rst_rd0", 2'd0, 32'd0);
        sl_read("rst_rd1", 2'd1, 32'd0);
        sl_read("rst_rd2", 2'd2, 32'd0);
        sl_read("rst_rd3", 2'd3, 32'd0);

        // Ramp up, interval 0
        sl_write(2'd0, 32'd100);
        sl_write(2'd1, 32'd10);
        sl_write(2'd2, 32'd4);
        push_wr(1'b0, 32'd100);
        push_wr(1'b1, 32'd0);
        push_wr(1'b1, 32'd4);
        push_wr(1'b1, 32'd8);
        push_wr(1'b1, 32'd10);
        wr_cyc.delete();
        sl_write(2'd3, 32'h0000_0001);
        sl_read("up_busy", 2'd3, 32'h0000_0001);
        wait_done("up_done_wait", 100);
        check("up_q_empty", exp_q.size(), 64'd0);
        check("up_div_lat", wr_cyc[0] - start_cyc, 64'd1);
        check("up_duty_lat", wr_cyc[1] - start_cyc, 64'd2);
        check("up_gap", wr_cyc[2] - wr_cyc[1], 64'd2);
        sl_read("up_stat", 2'd3, 32'h0000_0002);
        sl_read("up_cur", 2'd1, 32'd10);

        // Ramp down, interval 5
        sl_write(2'd1, 32'd1);
        sl_write(2'd2, 32'd3);
        push_wr(1'b0, 32'd100);
        push_wr(1'b1, 32'd10);
        push_wr(1'b1, 32'd7);
        push_wr(1'b1, 32'd4);
        push_wr(1'b1, 32'd1);
        wr_cyc.delete();
        sl_write(2'd3, (32'd5 << 16) | 32'd1);
        wait_done("dn_done_wait", 200);
        check("dn_q_empty", exp_q.size(), 64'd0);
        check("dn_gap1", wr_cyc[2] - wr_cyc[1], 64'd7);
        check("dn_gap3", wr_cyc[4] - wr_cyc[3], 64'd7);
        sl_read("dn_cur", 2'd1, 32'd1);
        sl_read("dn_stat", 2'd3, (32'd5 << 16) | 32'd2);

        // step = 0 jumps straight to target
        sl_write(2'd1, 32'd0);
        sl_write(2'd2, 32'd0);
        push_wr(1'b0, 32'd100);
        push_wr(1'b1, 32'd1);
        push_wr(1'b1, 32'd0);
        sl_write(2'd3, 32'h0000_0001);
        wait_done("z0_done_wait", 100);
        sl_write(2'd1, 32'd50);
        push_wr(1'b0, 32'd100);
        push_wr(1'b1, 32'd0);
        push_wr(1'b1, 32'd50);
        base = n_wr;
        sl_write(2'd3, 32'h0000_0001);
        wait_done("z50_done_wait", 100);
        check("z50_nwr", n_wr - base, 64'd3);
        sl_read("z50_cur", 2'd1, 32'd50);

        // Abort during WAIT
        sl_write(2'd1, 32'd40);
        sl_write(2'd2, 32'd5);
        // cur is 50; ramp down toward 40
        push_wr(1'b0, 32'd100);
        push_wr(1'b1, 32'd50);
        push_wr(1'b1, 32'd45);
        base = n_wr;
        sl_write(2'd3, (32'd10 << 16) | 32'd1);
        wait_writes("ab_wait_wr", base + 3, 100);
        repeat (3) @(negedge clk);
        sl_write(2'd3, (32'd10 << 16) | 32'd3);
        repeat (30) @(negedge clk);
        check("ab_nwr", n_wr - base, 64'd3);
        sl_read("ab_stat", 2'd3, 32'd10 << 16);
        sl_read("ab_cur", 2'd1, 32'd45);

        // Start while busy is ignored
        sl_write(2'd1, 32'd60);
        push_wr(1'b0, 32'd100);
        push_wr(1'b1, 32'd45);
        push_wr(1'b1, 32'd50);
        push_wr(1'b1, 32'd55);
        push_wr(1'b1, 32'd60);
        base = n_wr;
        sl_write(2'd3, (32'd3 << 16) | 32'd1);
        repeat (3) @(negedge clk);
        sl_write(2'd3, (32'd3 << 16) | 32'd1);
        wait_done("bz_done_wait", 200);
        repeat (5) @(negedge clk);
        check("bz_nwr", n_wr - base, 64'd5);
        check("bz_q_empty", exp_q.size(), 64'd0);
        sl_read("bz_stat", 2'd3, (32'd3 << 16) | 32'd2);

        // Reset mid-ramp
        sl_write(2'd1, 32'd0);
        sl_write(2'd2, 32'd1);
        push_wr(1'b0, 32'd100);
        push_wr(1'b1, 32'd60);
        base = n_wr;
        sl_write(2'd3, (32'd20 << 16) | 32'd1);
        wait_writes("rm_wait_wr", base + 2, 100);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #6;
        clr_n = 1'b0;
        #1;
        check("rm_m_cs", {63'd0, m_cs}, 64'd0);
        check("rm_m_wr_n", {63'd0, m_wr_n}, 64'd1);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        sl_read("rm_rd0", 2'd0, 32'd0);
        sl_read("rm_rd1", 2'd1, 32'd0);
        sl_read("rm_rd2", 2'd2, 32'd0);
        sl_read("rm_rd3", 2'd3, 32'd0);
        repeat (30) @(negedge clk);
        check("rm_nwr", n_wr - base, 64'd2);

`ifdef PWM_RAMP_SEQ_IRQ_EN
        sl_write(2'd0, 32'd7);
        sl_write(2'd1, 32'd2);
        sl_write(2'd2, 32'd1);
        push_wr(1'b0, 32'd7);
        push_wr(1'b1, 32'd0);
        push_wr(1'b1, 32'd1);
        push_wr(1'b1, 32'd2);
        sl_write(2'd3, 32'h0000_0005);
        wait_done("irq_done_wait", 100);
        check("irq_lag", {63'd0, irq}, 64'd0);
        @(negedge clk);
        check("irq_set", {63'd0, irq}, 64'd1);
        sl_write(2'd3, 32'h0000_000C);
        @(negedge clk);
        check("irq_clr", {63'd0, irq}, 64'd0);
        sl_read("irq_stat", 2'd3, 32'h0000_0004);
`endif

        check("final_q_empty", exp_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
